div_ctrl: RTL and testbench

Multi-cycle integer divide sequencer for DIV/DIVU in the pipeline's HI/LO write path.
- EX starts it, holds its operands stable and stalls the pipeline until `ready_o` is high.
- It then forwards `result_o` as hi/lo with whilo set, which flows through MEM/WB into the HI/LO register.
- One quotient bit per cycle (restoring shift-subtract), with a divide-by-zero shortcut and annul from pipeline flush.

---
 rtl/div_ctrl_pkg.sv | 20 ++
 rtl/div_ctrl_if.sv | 24 ++
 rtl/div_ctrl.sv | 148 ++++++++++++++
 tb/tb_div_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divide sequencer: state codes,
// handshake level names and the default operand width.
package div_ctrl_pkg;

  localparam int DEF_WIDTH = 32;

  // Sequencer states; codes are fixed so they match the rest of the pipeline.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake bundle between the EX stage (master) and the divide sequencer
// (slave). The result is a double-width word {remainder, quotient}.
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer. Restoring shift-subtract on operand
// magnitudes, one quotient bit per cycle, sign fix-up on the final cycle.
// A zero divisor skips the iterations but still finishes through the same
// final cycle, so a divide by zero reports two edges after the start.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]     quot_q, quot_d;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]     dvs_q, dvs_d;     // divisor magnitude
  logic                 neg1_q, neg1_d;   // dividend was negative (signed mode only)
  logic                 neg2_q, neg2_d;   // divisor was negative (signed mode only)
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH:0]       partial;
  logic [WIDTH:0]       diff;
  logic                 ge;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state, one restoring step, and the result presentation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;

    // Bring down the next dividend bit and trial-subtract the divisor.
    partial = {rem_q, quot_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
    ge      = (partial >= {1'b0, dvs_q});

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            // Signs only matter for DIV; DIVU treats both operands as magnitudes.
            neg1_d  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            neg2_d  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
            quot_d  = neg1_d ? negate(bus.opdata1_i) : bus.opdata1_i;
            dvs_d   = neg2_d ? negate(bus.opdata2_i) : bus.opdata2_i;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DivOn;
          end
        end
      end

      DivByZero: begin
        if (bus.annul_i) begin
          state_d = DivFree;
        end else begin
          // Zero magnitudes with the counter parked at the end: the next
          // DivOn cycle finalises a result of all zeros.
          rem_d   = '0;
          quot_d  = '0;
          neg1_d  = 1'b0;
          neg2_d  = 1'b0;
          cnt_d   = CNT_LAST;
          state_d = DivOn;
        end
      end

      DivOn: begin
        if (bus.annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else if (cnt_q < CNT_LAST) begin
          rem_d  = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], ge};
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend.
          result_d = {(neg1_q ? negate(rem_q) : rem_q),
                      ((neg1_q ^ neg2_q) ? negate(quot_q) : quot_q)};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        // Flush is signalled by EX dropping start, so annul is not looked at.
        if (bus.start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = (state_q != DivFree);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: unsigned/signed divides, divide by zero,
// annul, hold in DivEnd, and asynchronous reset mid-operation.
module tb_div_ctrl;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div_ctrl_if #(.WIDTH(W)) bus ();

  div_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a divide (start held high) and wait for ready_o. lat counts edges
  // after E0 at which ready_o was first seen; -1 means it never came.
  task automatic do_div(input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit scramble,
                        output int lat, output logic [2*W-1:0] res,
                        output bit busy_all);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    tick();                         // E0
    busy_all = (bus.busy_o === 1'b1);
    if (scramble) begin
      bus.signed_div_i = ~sgn;
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
    end
    lat = -1;
    res = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.busy_o !== 1'b1) busy_all = 0;
      if (bus.ready_o === 1'b1) begin
        lat = k;
        res = bus.result_o;
        break;
      end
    end
  endtask

  task automatic end_div();
    bus.start_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.result_o !== '0) begin
      failures++; $display("FAIL reset_result: got %h expected 0", bus.result_o);
    end
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
    end
    checks++;
    if (bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
    end
  endtask

  task automatic test_unsigned();
    int lat; logic [2*W-1:0] res; bit busy_all;
    do_div(1'b0, 32'd100, 32'd7, 0, lat, res, busy_all);
    checks++;
    if (lat != 33) begin
      failures++; $display("FAIL u100_7_latency: got %0d expected 33", lat);
    end
    checks++;
    if (res !== 64'h00000002_0000000E) begin
      failures++; $display("FAIL u100_7_result: got %h expected 000000020000000e", res);
    end
    checks++;
    if (!busy_all) begin
      failures++; $display("FAIL u100_7_busy: got dropped expected high E0..E33");
    end
    end_div();
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== '0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL u100_7_release: got ready=%b busy=%b result=%h expected 0/0/0",
               bus.ready_o, bus.busy_o, bus.result_o);
    end
  endtask

  task automatic test_signed();
    int lat; logic [2*W-1:0] res; bit busy_all;
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, lat, res, busy_all);
    checks++;
    if (lat != 33 || res !== 64'hFFFFFFFF_FFFFFFFD) begin
      failures++;
      $display("FAIL s_m7_2: got lat=%0d res=%h expected lat=33 res=fffffffffffffffd", lat, res);
    end
    end_div();
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, lat, res, busy_all);
    checks++;
    if (lat != 33 || res !== 64'h00000000_80000000) begin
      failures++;
      $display("FAIL s_min_m1: got lat=%0d res=%h expected lat=33 res=0000000080000000", lat, res);
    end
    end_div();
  endtask

  task automatic test_div_zero();
    int lat; logic [2*W-1:0] res; bit busy_all;
    do_div(1'b0, 32'd5, 32'd0, 0, lat, res, busy_all);
    checks++;
    if (lat != 2) begin
      failures++; $display("FAIL div0_latency: got %0d expected 2", lat);
    end
    checks++;
    if (res !== '0) begin
      failures++; $display("FAIL div0_result: got %h expected 0", res);
    end
    end_div();
  endtask

  task automatic test_hold_in_end();
    int lat; logic [2*W-1:0] res; bit busy_all; bit stable;
    do_div(1'b0, 32'hFFFFFFFF, 32'h10, 0, lat, res, busy_all);
    checks++;
    if (lat != 33 || res !== 64'h0000000F_0FFFFFFF) begin
      failures++;
      $display("FAIL u_ffff_10: got lat=%0d res=%h expected lat=33 res=0000000f0fffffff", lat, res);
    end
    stable = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h0000000F_0FFFFFFF) stable = 0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL hold_stable: got ready=%b result=%h expected 1 / 0000000f0fffffff",
               bus.ready_o, bus.result_o);
    end
    end_div();
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== '0) begin
      failures++;
      $display("FAIL hold_drop: got ready=%b result=%h expected 0/0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic test_annul();
    int lat; logic [2*W-1:0] res; bit busy_all; bit saw_ready;
    saw_ready = 0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    tick();                                  // E0, cnt=0
    for (int k = 1; k <= 10; k++) begin      // after E10, cnt=10
      tick();
      if (bus.ready_o !== 1'b0) saw_ready = 1;
    end
    bus.annul_i = 1'b1;
    tick();
    checks++;
    if (bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL annul_free: got busy=%b expected 0", bus.busy_o);
    end
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.ready_o !== 1'b0) saw_ready = 1;
    end
    checks++;
    if (saw_ready) begin
      failures++; $display("FAIL annul_no_ready: got ready seen expected never");
    end
    // Restart with operands changed after E0 to show they are latched.
    do_div(1'b0, 32'd9, 32'd3, 1, lat, res, busy_all);
    checks++;
    if (lat != 33 || res !== 64'h00000000_00000003) begin
      failures++;
      $display("FAIL restart_9_3: got lat=%0d res=%h expected lat=33 res=0000000000000003", lat, res);
    end
    end_div();
  endtask

  task automatic test_start_with_annul();
    bit stayed_free;
    stayed_free = 1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd10;
    bus.opdata2_i    = 32'd2;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.busy_o !== 1'b0) stayed_free = 0;
    end
    checks++;
    if (!stayed_free) begin
      failures++; $display("FAIL start_annul: got busy=1 expected 0");
    end
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat; logic [2*W-1:0] res; bit busy_all;
    do_div(1'b0, 32'd50, 32'd5, 0, lat, res, busy_all);
    end_div();
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 0, lat, res, busy_all);
    checks++;
    if (lat != 33 || res !== 64'h00000001_FFFFFFFD) begin
      failures++;
      $display("FAIL b2b_7_m2: got lat=%0d res=%h expected lat=33 res=00000001fffffffd", lat, res);
    end
    end_div();
  endtask

  task automatic test_async_reset();
    int lat; logic [2*W-1:0] res; bit busy_all;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd77;
    bus.opdata2_i    = 32'd5;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== '0) begin
      failures++;
      $display("FAIL async_rst: got busy=%b ready=%b result=%h expected 0/0/0",
               bus.busy_o, bus.ready_o, bus.result_o);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b0, 32'd8, 32'd2, 0, lat, res, busy_all);
    checks++;
    if (lat != 33 || res !== 64'h00000000_00000004) begin
      failures++;
      $display("FAIL post_rst_8_2: got lat=%0d res=%h expected lat=33 res=0000000000000004", lat, res);
    end
    end_div();
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_hold_in_end();
    test_annul();
    test_start_with_annul();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
